timer_counter: RTL and testbench

- Memory-mapped programmable down-counter on the CPU data bus, directly downstream of the mips core.
- Decodes the core's addr_cpu/din_cpu/we_cpu store traffic to its own registers.
- Provides read data for the bridge/DM mux.
- Drives one bit of the core's intq interrupt vector when a count expires.

---
 rtl/timer_counter.sv | 175 +++++++++++++++++
 tb/tb_timer_counter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with interrupt.
// Register window (16 bytes at BASE_ADDR): 0x0 CTRL, 0x4 PRESET, 0x8 COUNT,
// 0xC reserved, or PRESCALE when the TC_PRESCALE_EN macro is defined.
// CTRL: bit0 EN, bits2:1 MODE (01 auto-reload, anything else one-shot), bit3 IM.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        we,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;

  logic        sel;
  logic [1:0]  reg_sel;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        step_ok;
  logic        expire;
  logic        im_next;
  logic        unused_addr_bits;

  // Word-aligned register decode; byte offset bits carry no meaning here.
  assign sel              = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel          = addr[3:2];
  assign ctrl_wr          = sel & we & (reg_sel == 2'd0);
  assign preset_wr        = sel & we & (reg_sel == 2'd1);
  assign unused_addr_bits = ^addr[1:0];

  // MODE 1x deliberately falls back to one-shot behaviour.
  assign auto_reload = (mode == 2'b01);

  // The cycle on which the count reaches its end and the FSM enters INT.
  assign expire = (state == CNT) & en & step_ok & (count <= 32'd1);

  // IM as it will be after this edge: a simultaneous CTRL write wins.
  assign im_next = ctrl_wr ? din[3] : im;

`ifdef TC_PRESCALE_EN
  logic [15:0] prescale;
  logic [15:0] div;
  logic        prescale_wr;

  assign prescale_wr = sel & we & (reg_sel == 2'd3);
  assign step_ok     = (div == 16'd0);

  // PRESCALE register: CPU-writable divider setting.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= 16'd0;
    end else if (prescale_wr) begin
      prescale <= din[15:0];
    end
  end

  // Divider: restarts on LOAD, then lets COUNT step once every PRESCALE+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= 16'd0;
    end else if (state == LOAD) begin
      div <= prescale;
    end else if (state == CNT) begin
      div <= (div == 16'd0) ? prescale : div - 16'd1;
    end
  end
`else
  assign step_ok = 1'b1;
`endif

  // PRESET register: only sampled when the FSM passes through LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (preset_wr) begin
      preset <= din;
    end
  end

  // Control FSM, COUNT and CTRL; a CPU CTRL write overrides the FSM's EN clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 32'd0;
      en    <= 1'b0;
      mode  <= 2'b00;
      im    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            count <= preset;
            state <= CNT;
          end
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (step_ok) begin
            // PRESET=0 lands here immediately and expires like PRESET=1.
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= 32'd0;
              state <= INT;
            end
          end
        end
        INT: begin
          if (en && auto_reload) state <= LOAD;
          else                   state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (expire && !auto_reload) en <= 1'b0;

      if (ctrl_wr) begin
        en   <= din[0];
        mode <= din[2:1];
        im   <= din[3];
      end
    end
  end

  // Interrupt: sticky in one-shot mode, a single INT-cycle pulse in auto-reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (expire && im_next) begin
      irq <= 1'b1;
    end else if (ctrl_wr) begin
      irq <= 1'b0;
    end else if ((state == INT) && auto_reload) begin
      irq <= 1'b0;
    end
  end

  // Combinational read mux; unselected and reserved addresses read zero.
  always_comb begin
    dout = 32'd0;
    if (sel) begin
      case (reg_sel)
        2'd0:    dout = {28'd0, im, mode, en};
        2'd1:    dout = preset;
        2'd2:    dout = count;
        default: begin
`ifdef TC_PRESCALE_EN
          dout = {16'd0, prescale};
`else
          dout = 32'd0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed steps followed by random
// bus traffic, all compared against an elapsed-time reference model.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_INT  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .din  (din),
    .we   (we),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Reference model: COUNT while running is derived from elapsed cycles.
  bit          m_en;
  bit          m_im;
  bit [1:0]    m_mode;
  logic [31:0] m_preset;
  logic [15:0] m_prescale;
  int          m_phase;
  longint      m_hold;
  longint      m_n;
  longint      m_p;
  longint      m_k;
  bit          m_irq;

  function automatic longint m_count();
    if (m_phase == PH_RUN) return m_n - m_k / (m_p + 1);
    return m_hold;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0: return {28'd0, m_im, m_mode, m_en};
      2'd1: return m_preset;
      2'd2: return 32'(m_count());
      default: begin
`ifdef TC_PRESCALE_EN
        return {16'd0, m_prescale};
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic model_update();
    bit     wr;
    bit     cw;
    bit [1:0] ri;
    bit     fire;
    bit [1:0] old_mode;
    int     old_ph;
    int     nph;
    longint cur;
    longint span;
    wr = we && (addr[31:4] == BASE[31:4]);
    ri = addr[3:2];
    cw = wr && (ri == 2'd0);
    if (reset) begin
      m_en = 0; m_im = 0; m_mode = 2'b00;
      m_preset = 32'd0; m_prescale = 16'd0;
      m_phase = PH_IDLE; m_hold = 0; m_n = 0; m_p = 0; m_k = 0;
      m_irq = 0;
      return;
    end
    fire     = 0;
    old_mode = m_mode;
    old_ph   = m_phase;
    nph      = old_ph;
    cur      = m_count();
    case (old_ph)
      PH_IDLE: if (m_en) nph = PH_LOAD;
      PH_LOAD: begin
        if (!m_en) nph = PH_IDLE;
        else begin
          nph = PH_RUN;
          m_n = longint'(m_preset);
`ifdef TC_PRESCALE_EN
          m_p = longint'(m_prescale);
`else
          m_p = 0;
`endif
          m_k = 0;
        end
      end
      PH_RUN: begin
        span = ((m_n == 0) ? 64'sd1 : m_n) * (m_p + 1);
        if (!m_en) begin
          nph = PH_IDLE;
          m_hold = cur;
        end else if (m_k + 1 >= span) begin
          nph = PH_INT;
          m_hold = 0;
          fire = 1;
        end else begin
          m_k = m_k + 1;
        end
      end
      default: nph = (m_en && old_mode == 2'b01) ? PH_LOAD : PH_IDLE;
    endcase
    if (fire && old_mode != 2'b01) m_en = 0;
    m_phase = nph;
    if (cw) begin
      m_en   = din[0];
      m_mode = din[2:1];
      m_im   = din[3];
    end
    if (wr && ri == 2'd1) m_preset = din;
`ifdef TC_PRESCALE_EN
    if (wr && ri == 2'd3) m_prescale = din[15:0];
`endif
    if (fire && m_im) m_irq = 1;
    else if (cw) m_irq = 0;
    else if (old_ph == PH_INT && old_mode == 2'b01) m_irq = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("dout", dout, m_read(addr));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr_at(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    cycle();
    we = 1'b0; din = 32'd0;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    wr_at(BASE + {28'd0, off}, d);
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    int pulses;
    int r;
    logic [31:0] sh;
    reset = 1'b1; we = 1'b0; addr = BASE; din = 32'd0;

    // Reset for two cycles, then all registers read zero.
    run(2);
    reset = 1'b0;
    peek("rst_ctrl", BASE + 32'h0, 32'd0);
    peek("rst_preset", BASE + 32'h4, 32'd0);
    peek("rst_count", BASE + 32'h8, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    run(1);

    // One-shot with interrupt: PRESET=5, CTRL=0x9.
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    addr = BASE + 32'h8;
    run(2);
    chk("os_count_e2", dout, 32'd5);
    run(4);
    chk("os_count_e6", dout, 32'd1);
    chk("os_irq_e6", {31'd0, irq}, 32'd0);
    run(1);
    chk("os_irq_e7", {31'd0, irq}, 32'd1);
    chk("os_count_e7", dout, 32'd0);
    run(20);
    chk("os_irq_sticky", {31'd0, irq}, 32'd1);
    peek("os_ctrl", BASE, 32'h8);
    wr(4'h0, 32'h0);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: PRESET=3, CTRL=0xB gives a pulse every 5 cycles.
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    addr = BASE + 32'h8;
    pulses = 0;
    repeat (21) begin
      cycle();
      if (irq === 1'b1) pulses++;
    end
    chk("ar_pulses", 32'(pulses), 32'd4);
    run(1);
    chk("ar_reload_count", dout, 32'd3);
    wr(4'h0, 32'h0);
    run(2);

    // Masked one-shot: INT at E12, no irq, EN cleared.
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);
    addr = BASE + 32'h8;
    run(12);
    chk("nm_count_e12", dout, 32'd0);
    chk("nm_irq", {31'd0, irq}, 32'd0);
    run(1);
    peek("nm_ctrl", BASE, 32'h0);

    // Stop mid-count: COUNT freezes at 6.
    wr(4'h0, 32'h9);
    addr = BASE + 32'h8;
    run(5);
    wr(4'h0, 32'h0);
    addr = BASE + 32'h8;
    run(10);
    chk("frz_count", dout, 32'd6);
    chk("frz_irq", {31'd0, irq}, 32'd0);

    // Writes to COUNT and outside the window change nothing.
    wr_at(BASE + 32'h8, 32'hDEAD_BEEF);
    wr_at(BASE + 32'h10, 32'hDEAD_BEEF);
    peek("ign_preset", BASE + 32'h4, 32'd10);
    peek("ign_count", BASE + 32'h8, 32'd6);
    peek("ign_ctrl", BASE, 32'd0);
    peek("unsel_rd", BASE + 32'h10, 32'd0);
    run(1);
`ifndef TC_PRESCALE_EN
    peek("rsvd_rd", BASE + 32'hC, 32'd0);
`endif

    // PRESET=0 behaves as 1: irq at E3.
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h9);
    addr = BASE + 32'h8;
    run(2);
    chk("p0_irq_e2", {31'd0, irq}, 32'd0);
    run(1);
    chk("p0_irq_e3", {31'd0, irq}, 32'd1);
    wr(4'h0, 32'h0);
    run(2);

`ifdef TC_PRESCALE_EN
    // Prescaled: PRESCALE=2, PRESET=4 -> irq at E14.
    wr(4'hC, 32'd2);
    wr(4'h4, 32'd4);
    wr(4'h0, 32'h9);
    addr = BASE + 32'h8;
    run(13);
    chk("ps_irq_e13", {31'd0, irq}, 32'd0);
    run(1);
    chk("ps_irq_e14", {31'd0, irq}, 32'd1);
    wr(4'h0, 32'h0);
    run(2);
    // Reset at E8 of a fresh prescaled run.
    wr(4'h0, 32'h9);
    addr = BASE + 32'h8;
    run(7);
    chk("ps_count_e7", dout, 32'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("ps_rst_count", dout, 32'd0);
    chk("ps_rst_irq", {31'd0, irq}, 32'd0);
    run(3);
    chk("ps_idle_count", dout, 32'd0);
    peek("ps_rst_prescale", BASE + 32'hC, 32'd0);
    peek("ps_rst_ctrl", BASE, 32'd0);
    run(1);
`endif

    // Random bus traffic against the model.
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 99));
      reset = 1'b0; we = 1'b0; din = $urandom;
      addr = {BASE[31:4], 4'($urandom_range(0, 15))};
      if (r < 6) begin
        we = 1'b1;
        addr = {BASE[31:4], 2'b00, 2'($urandom_range(0, 3))};
        din = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15)) | ((r < 4) ? 32'd1 : 32'd0);
      end else if (r < 14) begin
        we = 1'b1;
        addr = BASE + 32'h4;
        din = 32'($urandom_range(0, 6));
      end else if (r < 18) begin
        we = 1'b1;
        addr = BASE + 32'h8;
      end else if (r < 21) begin
        we = 1'b1;
        sh = 32'h10;
        addr = BASE ^ (sh << $urandom_range(0, 27));
      end else if (r < 23) begin
`ifndef TC_PRESCALE_EN
        we = 1'b1;
        addr = BASE + 32'hC;
`endif
      end else if (r == 99) begin
        reset = 1'b1;
      end
      cycle();
    end
    reset = 1'b0; we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
